// File: rtl/sc_mmio_pkg.sv
// Shared constants for the MMIO data memory: I/O register offsets
// within the I/O page and the blank pattern for the 7-segment outputs.
package sc_mmio_pkg;

    localparam logic [7:0] OFS_SW         = 8'h00;
    localparam logic [7:0] OFS_KEY        = 8'h10;
    localparam logic [7:0] OFS_KEY_EDGE   = 8'h14;
    localparam logic [7:0] OFS_KEY_IRQ_EN = 8'h18;
    localparam logic [7:0] OFS_HEX0       = 8'h20;
    localparam logic [7:0] HEX_STRIDE     = 8'h10;
    localparam logic [7:0] OFS_LED        = 8'h80;
    localparam logic [7:0] OFS_CYCLES     = 8'h90;

    localparam logic [6:0] HEX_BLANK = 7'h7F;

    function automatic logic [7:0] hex_ofs(input int i);
        return OFS_HEX0 + HEX_STRIDE * 8'(i);
    endfunction

endpackage

// File: rtl/sc_key_sync_edge.sv
// Two-flop synchroniser for asynchronous board inputs, plus a delayed
// copy that yields a one-cycle pulse on each synchronised falling edge.
module sc_key_sync_edge #(
    parameter int W = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] sync,
    output logic [W-1:0] fall
);

    logic [W-1:0] s1;
    logic [W-1:0] s2;
    logic [W-1:0] s3;

    // Idle-high reset so released active-low keys do not fake an edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1 <= '1;
            s2 <= '1;
            s3 <= '1;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign sync = s2;
    assign fall = s3 & ~s2;

endmodule

// File: rtl/sc_mmio_datamem.sv
// CPU data memory: byte-enable word RAM with registered reads, plus a
// high-address I/O page (switches, keys with edge/irq, hex, LEDs, cycles).
module sc_mmio_datamem
    import sc_mmio_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 5,
    parameter int          NUM_HEX    = 6,
    parameter int          LED_W      = 10,
    parameter int          SW_W       = 10,
    parameter int          KEY_W      = 3,
    parameter logic [23:0] IO_PAGE    = 24'hFFFFFF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [31:0]          addr,
    input  logic [31:0]          datain,
    input  logic                 we,
    input  logic [3:0]           be,
    input  logic                 re,
    output logic [31:0]          dataout,
    output logic                 rd_valid,
    input  logic [SW_W-1:0]      sw,
    input  logic [KEY_W-1:0]     key,
    output logic [7*NUM_HEX-1:0] hex,
    output logic [LED_W-1:0]     led,
    output logic                 irq
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic                  io_sel;
    logic                  io_we;
    logic [7:0]            ofs;
    logic [DEPTH_LOG2-1:0] widx;

    assign io_sel = (addr[31:8] == IO_PAGE);
    assign io_we  = we & io_sel;
    assign ofs    = addr[7:0];
    assign widx   = addr[DEPTH_LOG2+1:2];

    logic [SW_W-1:0]  sw_sync;
    logic [SW_W-1:0]  sw_fall_unused;
    logic [KEY_W-1:0] key_sync;
    logic [KEY_W-1:0] key_fall;

    sc_key_sync_edge #(.W(SW_W)) u_sw_sync (
        .clock (clock),
        .reset (reset),
        .din   (sw),
        .sync  (sw_sync),
        .fall  (sw_fall_unused)
    );

    sc_key_sync_edge #(.W(KEY_W)) u_key_sync (
        .clock (clock),
        .reset (reset),
        .din   (key),
        .sync  (key_sync),
        .fall  (key_fall)
    );

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we && !io_sel) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[widx][8*b +: 8] <= datain[8*b +: 8];
                end
            end
        end
    end

    logic [6:0]       hex_q [NUM_HEX];
    logic [LED_W-1:0] led_q;
    logic [KEY_W-1:0] edge_q;
    logic [KEY_W-1:0] irq_en_q;
    logic [31:0]      cyc_q;
    logic [KEY_W-1:0] edge_clr;
    logic [31:0]      io_rdata;

    always_comb begin
        edge_clr = '0;
        if (io_we && ofs == OFS_KEY_EDGE) begin
            edge_clr = datain[KEY_W-1:0];
        end
    end

    // With 8 hex channels the last one aliases CYCLES; the counter wins.
    always_comb begin
        io_rdata = '0;
        case (ofs)
            OFS_SW:         io_rdata = 32'(sw_sync);
            OFS_KEY:        io_rdata = 32'(key_sync);
            OFS_KEY_EDGE:   io_rdata = 32'(edge_q);
            OFS_KEY_IRQ_EN: io_rdata = 32'(irq_en_q);
            OFS_LED:        io_rdata = 32'(led_q);
            OFS_CYCLES:     io_rdata = cyc_q;
            default: begin
                for (int i = 0; i < NUM_HEX; i++) begin
                    if (ofs == hex_ofs(i)) begin
                        io_rdata = 32'(hex_q[i]);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_HEX; i++) begin
                hex_q[i] <= HEX_BLANK;
            end
            led_q    <= '0;
            edge_q   <= '0;
            irq_en_q <= '0;
            cyc_q    <= '0;
            irq      <= 1'b0;
            dataout  <= '0;
            rd_valid <= 1'b0;
        end else begin
            cyc_q    <= cyc_q + 32'd1;
            edge_q   <= (edge_q & ~edge_clr) | key_fall;
            irq      <= |(edge_q & irq_en_q);
            rd_valid <= re;
            if (re) begin
                dataout <= io_sel ? io_rdata : mem[widx];
            end
            if (io_we) begin
                if (ofs == OFS_KEY_IRQ_EN) begin
                    irq_en_q <= datain[KEY_W-1:0];
                end
                if (ofs == OFS_LED) begin
                    led_q <= datain[LED_W-1:0];
                end
                for (int i = 0; i < NUM_HEX; i++) begin
                    if (ofs == hex_ofs(i)) begin
                        hex_q[i] <= datain[6:0];
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_HEX; g++) begin : g_hex
        assign hex[7*g +: 7] = hex_q[g];
    end

    assign led = led_q;

endmodule

// File: doc/sc_mmio_datamem.md
Name: sc_mmio_datamem

Overview:
- Parametrised successor to the single-cycle CPU data memory with high-address-mapped I/O.
- Contains an inferred word RAM with byte-enable writes and a 1-cycle registered read with a valid flag.
- Also provides a generalised I/O region: N seven-segment channels, LEDs, switches, synchronised keys with sticky edge capture and an interrupt, and a free-running cycle counter.
- Sits between the CPU load/store path and the board pins; uses one clock domain and no separate memory clock.

Parameters:
- DEPTH_LOG2, 5, RAM depth = 2**DEPTH_LOG2 32-bit words
- NUM_HEX, 6, number of 7-segment outputs (1..8)
- LED_W, 10, LED register width (1..32)
- SW_W, 10, switch input width (1..32)
- KEY_W, 3, key input width (1..8)
- IO_PAGE, 24'hFFFFFF, value of addr[31:8] that selects the I/O region

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- addr  in  32  byte address from CPU
- datain  in  32  store data
- we  in  1  store strobe, one cycle
- be  in  4  byte enables for the store; be[i] covers datain[8i+7:8i]
- re  in  1  load strobe, one cycle
- dataout  out  32  load data, registered
- rd_valid  out  1  high for exactly the one cycle after an accepted re
- sw  in  SW_W  raw switches, asynchronous
- key  in  KEY_W  raw push-buttons, asynchronous, active-low (0 = pressed)
- hex  out  7*NUM_HEX  segment drivers, active-low; channel i = hex[7i+6:7i]
- led  out  LED_W  LED drivers, active-high
- irq  out  1  OR of (key_edge & key_irq_en), registered

Behaviour:
- Reset values: dataout=0, rd_valid=0, all hex channels 7'h7F (blank), led=0, key_edge=0, key_irq_en=0, cycle counter=0, irq=0, synchroniser flops=all 1s. RAM contents are not reset.
- Region decode: io_sel = (addr[31:8]==IO_PAGE). Otherwise the access goes to RAM at word index addr[DEPTH_LOG2+1:2]. Higher bits are ignored, so addresses alias/wrap. addr[1:0] is ignored.
- RAM write: on we & ~io_sel, write each byte whose be bit is set. be=0 means no change.
- RAM read: on re & ~io_sel, dataout <= RAM word on the next edge and rd_valid=1. If re and we hit the same word in one cycle, dataout returns the OLD word (read-before-write).
- dataout holds its last value while re=0.
- I/O map (offset = addr[7:0]); writes use full-word data and ignore be unless stated:
  - 0x00 SW, RO: {zero-pad, sw_sync}
  - 0x10 KEY, RO: {zero-pad, key_sync}, raw synchronised level
  - 0x14 KEY_EDGE, RW1C: set on falling edge of key_sync[i]; a write with datain[i]=1 clears bit i. Same-cycle set and clear: set wins.
  - 0x18 KEY_IRQ_EN, RW: low KEY_W bits
  - 0x20+0x10*i, i<NUM_HEX, HEX i, RW: datain[6:0]
  - 0x80 LED, RW: datain[LED_W-1:0]
  - 0x90 CYCLES, RO: 32-bit counter, +1 every clock, wraps FFFFFFFF->0
  - Any other offset: reads return 0, writes are ignored. Writes to RO registers are ignored.
- I/O reads have the same 1-cycle latency and rd_valid behaviour as RAM reads.
- Synchronisation: sw and key each pass through 2 flops. An edge is detected on the 3rd flop vs the 2nd. Key edge latency is 3 clocks from the pin change to the key_edge bit being set; irq follows 1 clock later.
- we and re asserted together to different addresses: both are performed.
- Asynchronous reset mid-access: the access is lost and rd_valid=0 immediately.

Decomposition:
- Package sc_mmio_pkg holds:
  - the offset localparams (OFS_SW, OFS_KEY, OFS_KEY_EDGE, OFS_KEY_IRQ_EN, OFS_HEX0, HEX_STRIDE, OFS_LED, OFS_CYCLES)
  - HEX_BLANK = 7'h7F
- Sub-module sc_key_sync_edge (parameter W): 2-flop synchroniser, delayed copy, falling-edge pulse output. It is instantiated for keys with edge detection used, and for switches with the edge output left unused.

Test Plan:
- Reset, then read 0x00000000 and 0xFFFFFF20..0xFFFFFF70 -> rd_valid one cycle later. Hex reads return 0x7F; led=0; irq=0.
- Write 0x11223344 to 0x00000008 with be=4'hF, then write 0xAABBCCDD to the same address with be=4'b0101, then read -> 0x11BB33DD after 1 clock. Reading 0x00000088 (DEPTH_LOG2=5) returns the same value (wrap).
- Same cycle: we=1 datain=0x5 and re=1 to word 3, which previously held 0x9 -> dataout=0x9. The next read returns 0x5.
- Write 0x3F to 0xFFFFFF40 and 0x2AA to 0xFFFFFF80 -> hex[20:14]=7'h3F and led=10'h2AA on the next edge. Writing 0x1234 to 0xFFFFFF00 leaves the SW read unchanged.
- KEY_IRQ_EN=3'b010; drive key[1] 1->0 -> KEY_EDGE reads 3'b010 and irq=1 four clocks after the pin change. Writing 3'b010 to 0xFFFFFF14 clears the bit and drops irq. A new edge on the same cycle as the clear leaves the bit set.
- Read CYCLES twice, 10 clocks apart -> difference is 10. Force the counter to 0xFFFFFFFE by reset plus a wait or a bench backdoor; two clocks later it reads 0x00000000.
